// File: rtl/seq_divider_restoring.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_restoring
// Description : Iterative unsigned restoring divider, one quotient bit per
//               clock, with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_restoring #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_div;
    logic [WIDTH-1:0]   r_rem;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic               w_last;
    logic               w_div_zero;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_q_next;

    // The restored partial remainder is always below the divisor, so its
    // extra (WIDTH+1-th) bit is identically zero and is not stored.
    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_div};
    assign w_fits     = ~w_diff[WIDTH];
    assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_fits};
    assign w_last     = (r_cnt == c_LAST);
    assign w_div_zero = (divisor == '0);

    assign busy = (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !w_div_zero) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_div_zero) begin
                            // Division by zero resolves immediately without iterating
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            r_q   <= dividend;
                            r_div <= divisor;
                            r_rem <= '0;
                            r_cnt <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        quotient    <= w_q_next;
                        remainder   <= w_rem_next;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider_restoring.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider_restoring
// Description : Self-checking bench for seq_divider_restoring (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_divider_restoring;

    localparam int WIDTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_divider_restoring #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; issues one request and waits for its done pulse.
    // poke >= 0 raises start (3/3) for one cycle at that point of the run.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] q, input logic [3:0] r,
                         input logic dz, input int poke);
        int         lat;
        int         busy_cnt;
        bit         hold_ok;
        logic [3:0] pq;
        logic [3:0] pr;
        logic       pdz;
        lat      = 0;
        busy_cnt = 0;
        hold_ok  = 1'b1;
        pq       = quotient;
        pr       = remainder;
        pdz      = div_by_zero;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (quotient != pq || remainder != pr || div_by_zero != pdz) hold_ok = 1'b0;
            if (lat == poke) begin
                start    = 1'b1;
                dividend = 4'd3;
                divisor  = 4'd3;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        chk("latency",      lat,         dz ? 0 : WIDTH);
        chk("busy_cycles",  busy_cnt,    dz ? 0 : WIDTH);
        chk("result_hold",  int'(hold_ok), 1);
        chk("busy_at_done", int'(busy),  0);
        chk("quotient",     quotient,    q);
        chk("remainder",    remainder,   r);
        chk("div_by_zero",  div_by_zero, dz);
        if (b != 0) begin
            chk("invariant",  int'(quotient) * int'(b) + int'(remainder), int'(a));
            chk("rem_lt_div", int'(remainder < b), 1);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("done_width", int'(done), 0);
        chk("idle_busy",  int'(busy), 0);
    endtask

    initial begin
        int         order [256];
        int         tmp;
        int         j;
        int         gap;
        logic [3:0] a;
        logic [3:0] b;
        bit         saw_done;

        vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0};
        vecs[1] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1};
        vecs[2] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0};
        vecs[3] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        vecs[5] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1};
        vecs[6] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0};
        vecs[7] = '{4'd15, 4'd2,  4'd7,  4'd1, 1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy",  int'(busy),        0);
        chk("reset_done",  int'(done),        0);
        chk("reset_q",     quotient,          0);
        chk("reset_r",     remainder,         0);
        chk("reset_dz",    int'(div_by_zero), 0);
        chk("reset_x",     int'($isunknown({busy, done, quotient, remainder, div_by_zero})), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, -1);
            idle_cycle();
        end

        // Back-to-back requests issued in the done cycle
        issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, -1);
        issue(4'd5,  4'd7, 4'd0,  4'd5, 1'b0, -1);
        issue(4'd9,  4'd0, 4'd15, 4'd9, 1'b1, -1);
        issue(4'd6,  4'd0, 4'd15, 4'd6, 1'b1, -1);
        issue(4'd8,  4'd2, 4'd4,  4'd0, 1'b0, -1);
        idle_cycle();

        // Start during busy must be ignored, single done pulse
        issue(4'd12, 4'd5, 4'd2, 4'd2, 1'b0, 1);
        repeat (3) idle_cycle();

        // Reset in the second RUN cycle aborts the operation
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy),        0);
        chk("abort_done", int'(done),        0);
        chk("abort_q",    quotient,          0);
        chk("abort_r",    remainder,         0);
        chk("abort_dz",   int'(div_by_zero), 0);
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort_no_done", int'(saw_done), 0);
        issue(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, -1);
        idle_cycle();

        // All operand pairs in shuffled order with random gaps
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j        = int'($urandom_range(i, 0));
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            a = 4'(order[i] >> 4);
            b = 4'(order[i]);
            if (b == 0) issue(a, b, 4'd15, a, 1'b1, -1);
            else        issue(a, b, a / b, a % b, 1'b0, -1);
            gap = int'($urandom_range(2, 0));
            repeat (gap) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
